// File: rtl/retire_port_arbiter.sv
// Round-robin arbiter sharing the single ROB write port among RETIRE_PORT_NUM completion ports.
// Optional per-port grant counters are enabled by defining RETIRE_ARB_PERF_CNT_EN.
module retire_port_arbiter #(
    parameter int unsigned RETIRE_PORT_NUM = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    localparam int unsigned IDX_W = (RETIRE_PORT_NUM > 1) ? $clog2(RETIRE_PORT_NUM) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [RETIRE_PORT_NUM-1:0]            req_valid_i,
    output logic [RETIRE_PORT_NUM-1:0]            req_ready_o,
    input  logic [RETIRE_PORT_NUM*DATA_WIDTH-1:0] req_data_i,
    output logic                                  rob_valid_o,
    input  logic                                  rob_ready_i,
    output logic [DATA_WIDTH-1:0]                 rob_data_o,
    output logic [IDX_W-1:0]                      rob_port_o,
    input  logic                                  flush_i,
`ifdef RETIRE_ARB_PERF_CNT_EN
    output logic [RETIRE_PORT_NUM*32-1:0]         grant_cnt_o,
`endif
    output logic                                  busy_o
);

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      win;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      ptr_next;
    logic [IDX_W:0]        sum;
    logic [IDX_W:0]        nsum;
    logic                  found;
    logic                  free;
    logic                  grant;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]      port_q;

    assign free = ~valid_q | rob_ready_i;

    // Search ptr, ptr+1, ... modulo the port count; first valid port wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < RETIRE_PORT_NUM; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(RETIRE_PORT_NUM)) begin
                sum = sum - (IDX_W+1)'(RETIRE_PORT_NUM);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        grant = found & free & ~flush_i & ~rst_i;
    end

    always_comb begin
        req_ready_o = '0;
        win_data    = '0;
        for (int unsigned k = 0; k < RETIRE_PORT_NUM; k++) begin
            req_ready_o[k] = grant && (win == IDX_W'(k));
            if (win == IDX_W'(k)) begin
                win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        nsum = {1'b0, win} + (IDX_W+1)'(1);
        if (nsum >= (IDX_W+1)'(RETIRE_PORT_NUM)) begin
            nsum = nsum - (IDX_W+1)'(RETIRE_PORT_NUM);
        end
        ptr_next = nsum[IDX_W-1:0];
    end

    // A drain and a new grant in the same cycle simply overwrite the register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            port_q  <= '0;
            ptr_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (grant) begin
            valid_q <= 1'b1;
            data_q  <= win_data;
            port_q  <= win;
            ptr_q   <= ptr_next;
        end else if (rob_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign rob_valid_o = valid_q;
    assign rob_data_o  = data_q;
    assign rob_port_o  = port_q;
    assign busy_o      = valid_q | (|req_valid_i);

`ifdef RETIRE_ARB_PERF_CNT_EN
    logic [31:0] cnt_q [RETIRE_PORT_NUM];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < RETIRE_PORT_NUM; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < RETIRE_PORT_NUM; k++) begin
                if (req_valid_i[k] && req_ready_o[k]) begin
                    cnt_q[k] <= cnt_q[k] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int unsigned k = 0; k < RETIRE_PORT_NUM; k++) begin
            grant_cnt_o[k*32 +: 32] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_retire_port_arbiter.sv
// Directed self-checking bench for retire_port_arbiter (4 ports, 32-bit payload).
// Counter checks run only when RETIRE_ARB_PERF_CNT_EN is defined.
module tb_retire_port_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic            rob_valid;
    logic            rob_ready;
    logic [DW-1:0]   rob_data;
    logic [1:0]      rob_port;
    logic            flush;
    logic            busy;
`ifdef RETIRE_ARB_PERF_CNT_EN
    logic [N*32-1:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    retire_port_arbiter #(
        .RETIRE_PORT_NUM(N),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_data_i (req_data),
        .rob_valid_o(rob_valid),
        .rob_ready_i(rob_ready),
        .rob_data_o (rob_data),
        .rob_port_o (rob_port),
        .flush_i    (flush),
`ifdef RETIRE_ARB_PERF_CNT_EN
        .grant_cnt_o(grant_cnt),
`endif
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int unsigned port, input logic [DW-1:0] value);
        req_data[port*DW +: DW] = value;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        rob_ready = 1'b1;
        req_valid = 4'b1111;
        req_data  = '0;

        // Reset asserted before any clock edge: outputs must clear immediately.
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 64'(rob_valid), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        step();
        check("rst_data", 64'(rob_data), 64'd0);
        check("rst_port", 64'(rob_port), 64'd0);
        rst = 1'b0;

        // Fairness: all ports valid, ready high.
        for (int k = 0; k < 4; k++) set_data(k, 32'h100 + k);
        #1;
        check("first_grant", 64'(req_ready), 64'b0001);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_valid", 64'(rob_valid), 64'd1);
            check("rr_port", 64'(rob_port), 64'(i % 4));
            check("rr_data", 64'(rob_data), 64'(32'h100 + (i % 4)));
            check("rr_ready", 64'(req_ready), 64'(4'b0001 << ((i + 1) % 4)));
        end

        // Backpressure: port2 payload 0xA5 held while ROB stalls.
        req_valid = 4'b0100;
        set_data(2, 32'hA5);
        #1;
        check("bp_ready", 64'(req_ready), 64'b0100);
        step();
        check("bp_data", 64'(rob_data), 64'hA5);
        req_valid = 4'b0001;
        set_data(0, 32'h11);
        rob_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_stall_ready", 64'(req_ready), 64'd0);
            step();
            check("bp_hold_valid", 64'(rob_valid), 64'd1);
            check("bp_hold_data", 64'(rob_data), 64'hA5);
            check("bp_hold_port", 64'(rob_port), 64'd2);
        end
        rob_ready = 1'b1;
        #1;
        check("bp_drain_grant", 64'(req_ready), 64'b0001);
        step();
        check("bp_new_data", 64'(rob_data), 64'h11);
        check("bp_new_port", 64'(rob_port), 64'd0);

        // Pointer skip: ptr=1, ports 0 and 3 valid.
        req_valid = 4'b1001;
        set_data(3, 32'h33);
        set_data(0, 32'h44);
        #1;
        check("skip_ready3", 64'(req_ready), 64'b1000);
        step();
        check("skip_port3", 64'(rob_port), 64'd3);
        check("skip_data3", 64'(rob_data), 64'h33);
        req_valid = 4'b0001;
        #1;
        check("skip_ready0", 64'(req_ready), 64'b0001);
        step();
        check("skip_port0", 64'(rob_port), 64'd0);
        check("skip_data0", 64'(rob_data), 64'h44);
        req_valid = 4'b0000;
        #1;
        check("busy_held", 64'(busy), 64'd1);
        step();
        check("drain_valid", 64'(rob_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        req_valid = 4'b0011;
        #1;
        check("ptr_at_1", 64'(req_ready), 64'b0010);

        // Flush: hold a port0 entry (ptr becomes 1), then flush with ports 0/1 valid.
        req_valid = 4'b0001;
        set_data(0, 32'h55);
        rob_ready = 1'b0;
        step();
        check("fl_held", 64'(rob_data), 64'h55);
        req_valid = 4'b0011;
        set_data(0, 32'h77);
        set_data(1, 32'h66);
        rob_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("fl_ready", 64'(req_ready), 64'd0);
        step();
        check("fl_valid", 64'(rob_valid), 64'd0);
        flush = 1'b0;
        #1;
        check("fl_restart", 64'(req_ready), 64'b0001);
        step();
        check("fl_port", 64'(rob_port), 64'd0);
        check("fl_data", 64'(rob_data), 64'h77);

        // Asynchronous reset mid-transfer discards the held entry.
        req_valid = 4'b0000;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(rob_valid), 64'd0);
        check("mid_rst_data", 64'(rob_data), 64'd0);
        step();
        rst = 1'b0;

        // Counters: 5 grants on port1, 2 on port3, then a flush.
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        check("cnt_p1_port", 64'(rob_port), 64'd1);
        req_valid = 4'b1000;
        for (int i = 0; i < 2; i++) step();
        check("cnt_p3_port", 64'(rob_port), 64'd3);
        req_valid = 4'b0000;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cnt_flush_valid", 64'(rob_valid), 64'd0);
`ifdef RETIRE_ARB_PERF_CNT_EN
        check("cnt_p0", 64'(grant_cnt[0*32 +: 32]), 64'd0);
        check("cnt_p1", 64'(grant_cnt[1*32 +: 32]), 64'd5);
        check("cnt_p2", 64'(grant_cnt[2*32 +: 32]), 64'd0);
        check("cnt_p3", 64'(grant_cnt[3*32 +: 32]), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
